// File: rtl/axi_wr_sched_pkg.sv
// Shared types and address map for the AXI write scheduler.
// The read path reuses the same map.
package axi_wr_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_e;

  typedef enum logic [2:0] {
    SEL_DEF = 3'd0,
    SEL_S1,
    SEL_S2,
    SEL_S3,
    SEL_S4,
    SEL_S5
  } slave_sel_e;

  localparam int NUM_MST = 2;
  localparam int NUM_SLV = 5;

  localparam logic [31:0] S1_BASE  = 32'h0000_0000;
  localparam logic [31:0] S1_LIMIT = 32'h0000_FFFF;
  localparam logic [31:0] S2_BASE  = 32'h0001_0000;
  localparam logic [31:0] S2_LIMIT = 32'h0001_FFFF;
  localparam logic [31:0] S3_BASE  = 32'h0002_0000;
  localparam logic [31:0] S3_LIMIT = 32'h0002_FFFF;
  localparam logic [31:0] S4_BASE  = 32'h1000_0000;
  localparam logic [31:0] S4_LIMIT = 32'h1000_03FF;
  localparam logic [31:0] S5_BASE  = 32'h2000_0000;
  localparam logic [31:0] S5_LIMIT = 32'h201F_FFFF;

  localparam logic [NUM_SLV-1:0][31:0] SLV_BASE  =
    {S5_BASE, S4_BASE, S3_BASE, S2_BASE, S1_BASE};
  localparam logic [NUM_SLV-1:0][31:0] SLV_LIMIT =
    {S5_LIMIT, S4_LIMIT, S3_LIMIT, S2_LIMIT, S1_LIMIT};

  // Every window is power-of-two sized and size-aligned, so a mask compare suffices.
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] base,
                                  input logic [31:0] limit);
    return ((a & ~(limit - base)) == base);
  endfunction

endpackage

// File: rtl/axi_wr_sched_if.sv
// Request, handshake and steering signals between the masters/slaves and the write scheduler.
interface axi_wr_sched_if;
  logic        AWVALID_M0;
  logic [31:0] AWADDR_M0;
  logic        AWVALID_M1;
  logic [31:0] AWADDR_M1;
  logic        AWREADY_sel;
  logic        WVALID_sel;
  logic        WREADY_sel;
  logic        WLAST_sel;
  logic        BVALID_sel;
  logic        BREADY_sel;
  logic [1:0]  grant;
  logic [2:0]  slave_sel;
  logic        aw_phase;
  logic        w_phase;
  logic        b_phase;
  logic        wr_timeout;

  modport slave (
    input  AWVALID_M0, AWADDR_M0, AWVALID_M1, AWADDR_M1, AWREADY_sel,
           WVALID_sel, WREADY_sel, WLAST_sel, BVALID_sel, BREADY_sel,
    output grant, slave_sel, aw_phase, w_phase, b_phase, wr_timeout
  );

  modport master (
    output AWVALID_M0, AWADDR_M0, AWVALID_M1, AWADDR_M1, AWREADY_sel,
           WVALID_sel, WREADY_sel, WLAST_sel, BVALID_sel, BREADY_sel,
    input  grant, slave_sel, aw_phase, w_phase, b_phase, wr_timeout
  );
endinterface

// File: rtl/axi_wr_sched_addr_dec.sv
// Combinational AWADDR/ARADDR to slave-select decode; unmapped addresses go to the default slave.
module axi_wr_addr_dec
  import axi_wr_pkg::*;
(
  input  logic [31:0] addr,
  output slave_sel_e  sel
);

  always_comb begin
    sel = SEL_DEF;
    for (int i = 0; i < NUM_SLV; i++)
      if (in_win(addr, SLV_BASE[i], SLV_LIMIT[i])) sel = slave_sel_e'(3'(i + 1));
  end

endmodule

// File: rtl/axi_wr_sched.sv
// Two-master write scheduler: round-robin AW arbitration, route lock across AW/W/B,
// stall watchdog on the W and B phases.
module axi_wr_sched
  import axi_wr_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  axi_wr_sched_if.slave bus
);

  wr_state_e                state, state_nxt;
  logic [NUM_MST-1:0]       awvalid, grant_q;
  logic [NUM_MST-1:0][31:0] awaddr;
  slave_sel_e               dec_sel [NUM_MST];
  slave_sel_e               sel_q;
  logic                     last_grant, win;
  logic [CNT_W-1:0]         stall_cnt;
  logic                     wr_timeout_q;
  logic                     aw_hs, w_hs, b_hs, stall, timeout_hit, route_done, grant_now;
  logic                     aw_ph, w_ph, b_ph;

  assign awvalid = {bus.AWVALID_M1, bus.AWVALID_M0};
  assign awaddr  = {bus.AWADDR_M1, bus.AWADDR_M0};

  for (genvar g = 0; g < NUM_MST; g++) begin : g_dec
    axi_wr_addr_dec u_dec (.addr(awaddr[g]), .sel(dec_sel[g]));
  end

  // win=1 selects M1; on a tie the master that did not win last time goes first
  assign win       = (&awvalid) ? ~last_grant : awvalid[1];
  assign grant_now = (state == IDLE) && (|awvalid);

  assign aw_hs = (|(grant_q & awvalid)) & bus.AWREADY_sel;
  assign w_hs  = bus.WVALID_sel & bus.WREADY_sel;
  assign b_hs  = bus.BVALID_sel & bus.BREADY_sel;

  assign stall       = ((state == DATA) && !w_hs) || ((state == RESP) && !b_hs);
  assign timeout_hit = stall && (stall_cnt == CNT_W'(TIMEOUT - 1));
  assign route_done  = ((state == RESP) && b_hs) || timeout_hit;

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|awvalid) state_nxt = ADDR;
      ADDR:    if (aw_hs) state_nxt = DATA;
      DATA:    if (timeout_hit) state_nxt = IDLE;
               else if (w_hs && bus.WLAST_sel) state_nxt = RESP;
      RESP:    if (route_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    aw_ph = 1'b0;
    w_ph  = 1'b0;
    b_ph  = 1'b0;
    case (state)
      ADDR:    aw_ph = 1'b1;
      DATA:    w_ph  = 1'b1;
      RESP:    b_ph  = 1'b1;
      default: ;
    endcase
  end

  // Route is captured once in IDLE and held until B completes or the watchdog fires
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      grant_q      <= '0;
      sel_q        <= SEL_DEF;
      last_grant   <= 1'b1;
      stall_cnt    <= '0;
      wr_timeout_q <= 1'b0;
    end else begin
      wr_timeout_q <= timeout_hit;
      if (grant_now) begin
        grant_q    <= win ? 2'b10 : 2'b01;
        sel_q      <= dec_sel[win];
        last_grant <= win;
      end else if (route_done) begin
        grant_q <= '0;
        sel_q   <= SEL_DEF;
      end
      if (stall && !timeout_hit) stall_cnt <= stall_cnt + 1'b1;
      else                       stall_cnt <= '0;
    end

  assign bus.grant      = grant_q;
  assign bus.slave_sel  = sel_q;
  assign bus.aw_phase   = aw_ph;
  assign bus.w_phase    = w_ph;
  assign bus.b_phase    = b_ph;
  assign bus.wr_timeout = wr_timeout_q;

endmodule

// File: tb/tb_axi_wr_sched.sv
// Randomized self-checking bench for axi_wr_sched against a transaction-level model.
module tb_axi_wr_sched;
  localparam int TIMEOUT = 1024;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi_wr_sched_if bus ();

  axi_wr_sched #(.TIMEOUT(TIMEOUT), .CNT_W(11)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  bit mdl_last = 1'b1;  // model of last winner, 1 = M1

  logic [31:0] addr_tab [14] = '{
    32'h0000_0000, 32'h0000_FFFF, 32'h0001_0000, 32'h0001_FFFF, 32'h0002_0000,
    32'h0002_FFFF, 32'h0003_0000, 32'h0FFF_FFFF, 32'h1000_0000, 32'h1000_03FF,
    32'h1000_0400, 32'h2000_0000, 32'h201F_FFFF, 32'h2020_0000
  };

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs;
    bus.AWVALID_M0 = 0; bus.AWADDR_M0 = '0; bus.AWVALID_M1 = 0; bus.AWADDR_M1 = '0;
    bus.AWREADY_sel = 0; bus.WVALID_sel = 0; bus.WREADY_sel = 0; bus.WLAST_sel = 0;
    bus.BVALID_sel = 0; bus.BREADY_sel = 0;
  endtask

  function automatic logic [2:0] ref_slave(input logic [31:0] a);
    if (a <= 32'h0000_FFFF) return 3'd1;
    if (a <= 32'h0001_FFFF) return 3'd2;
    if (a <= 32'h0002_FFFF) return 3'd3;
    if (a >= 32'h1000_0000 && a <= 32'h1000_03FF) return 3'd4;
    if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 3'd5;
    return 3'd0;
  endfunction

  // Round-robin model: returns the winning master index and remembers it
  function automatic bit ref_winner(input bit r0, input bit r1);
    bit w;
    w = (r0 && r1) ? !mdl_last : r1;
    mdl_last = w;
    return w;
  endfunction

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 2) == 0) return $urandom;
    return addr_tab[$urandom_range(0, 13)];
  endfunction

  // Drives one complete AW/W/B transaction and records what the DUT showed along the way
  task automatic run_txn(input bit r0, input bit r1, input logic [31:0] a0, input logic [31:0] a1,
                         input int aw_wait, input int beats, input bit toggle, input int b_wait,
                         output logic [1:0] g, output logic [2:0] s, output int n_addr,
                         output int n_data, output int n_resp, output int n_to,
                         output logic [1:0] g_end, output bit seq_ok);
    int beat, cyc;
    n_addr = 0; n_data = 0; n_resp = 0; n_to = 0; seq_ok = 1;
    bus.AWVALID_M0 = r0; bus.AWVALID_M1 = r1; bus.AWADDR_M0 = a0; bus.AWADDR_M1 = a1;
    tick;
    g = bus.grant;
    s = bus.slave_sel;
    for (int i = 0; i <= aw_wait; i++) begin
      n_addr += int'(bus.aw_phase);
      n_to   += int'(bus.wr_timeout);
      if ({bus.aw_phase, bus.w_phase, bus.b_phase} !== 3'b100 || bus.slave_sel !== s ||
          bus.grant !== g) seq_ok = 0;
      bus.AWADDR_M0 = $urandom;
      bus.AWADDR_M1 = $urandom;
      bus.AWREADY_sel = (i == aw_wait);
      tick;
    end
    bus.AWVALID_M0 = 0; bus.AWVALID_M1 = 0; bus.AWREADY_sel = 0;
    beat = 0;
    cyc = 0;
    while (beat < beats) begin
      n_data += int'(bus.w_phase);
      n_to   += int'(bus.wr_timeout);
      if ({bus.aw_phase, bus.w_phase, bus.b_phase} !== 3'b010 || bus.grant !== g) seq_ok = 0;
      bus.WVALID_sel = 1;
      bus.WREADY_sel = toggle ? (cyc % 2 == 1) : 1'b1;
      bus.WLAST_sel  = (beat == beats - 1);
      tick;
      if (bus.WREADY_sel) beat++;
      cyc++;
    end
    bus.WVALID_sel = 0; bus.WREADY_sel = 0; bus.WLAST_sel = 0;
    for (int i = 0; i <= b_wait; i++) begin
      n_resp += int'(bus.b_phase);
      n_to   += int'(bus.wr_timeout);
      if ({bus.aw_phase, bus.w_phase, bus.b_phase} !== 3'b001 || bus.grant !== g) seq_ok = 0;
      bus.BVALID_sel = (i == b_wait);
      bus.BREADY_sel = 1;
      tick;
    end
    bus.BVALID_sel = 0; bus.BREADY_sel = 0;
    g_end = bus.grant;
    n_to += int'(bus.wr_timeout);
    if ({bus.aw_phase, bus.w_phase, bus.b_phase} !== 3'b000 || bus.slave_sel !== 3'd0) seq_ok = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    ARESETn = 0;
    tick; tick;
    checks++;
    if ({bus.grant, bus.slave_sel, bus.aw_phase, bus.w_phase, bus.b_phase, bus.wr_timeout} !== 9'd0) begin
      failures++;
      $display("FAIL reset_hold: got grant=%b sel=%0d ph=%b%b%b to=%b want all zero", bus.grant,
               bus.slave_sel, bus.aw_phase, bus.w_phase, bus.b_phase, bus.wr_timeout);
    end
    @(negedge ACLK);
    ARESETn = 1;
    mdl_last = 1;
    tick; tick;
    checks++;
    if ({bus.grant, bus.slave_sel, bus.aw_phase, bus.w_phase, bus.b_phase, bus.wr_timeout} !== 9'd0) begin
      failures++;
      $display("FAIL reset_idle: got grant=%b sel=%0d ph=%b%b%b want all zero with no request",
               bus.grant, bus.slave_sel, bus.aw_phase, bus.w_phase, bus.b_phase);
    end
  endtask

  task automatic test_tie;
    logic [1:0] g, g_end; logic [2:0] s; int na, nd, nr, nt; bit ok;
    logic [31:0] a0, a1;
    logic [1:0] exp_g [2] = '{2'b01, 2'b10};
    for (int k = 0; k < 2; k++) begin
      a0 = pick_addr(); a1 = pick_addr();
      void'(ref_winner(1, 1));
      run_txn(1, 1, a0, a1, 0, 2, 0, 0, g, s, na, nd, nr, nt, g_end, ok);
      checks++;
      if (g !== exp_g[k]) begin
        failures++;
        $display("FAIL tie_grant%0d: got %b want %b", k, g, exp_g[k]);
      end
      checks++;
      if (s !== ref_slave(k == 0 ? a0 : a1)) begin
        failures++;
        $display("FAIL tie_sel%0d: got %0d want %0d", k, s, ref_slave(k == 0 ? a0 : a1));
      end
    end
  endtask

  task automatic test_single_m1;
    logic [1:0] g, g_end; logic [2:0] s; int na, nd, nr, nt; bit ok;
    void'(ref_winner(0, 1));
    run_txn(0, 1, 32'hDEAD_BEEF, 32'h0002_0010, 0, 4, 0, 0, g, s, na, nd, nr, nt, g_end, ok);
    checks++;
    if (g !== 2'b10 || s !== 3'd3) begin
      failures++;
      $display("FAIL single_route: got grant=%b sel=%0d want 10/3", g, s);
    end
    checks++;
    if (!ok || na != 1 || nd != 4 || nr != 1) begin
      failures++;
      $display("FAIL single_phases: got ok=%0d addr=%0d data=%0d resp=%0d want 1/1/4/1", ok, na, nd, nr);
    end
    checks++;
    if (g_end !== 2'b00 || nt != 0) begin
      failures++;
      $display("FAIL single_release: got grant=%b timeouts=%0d want 00/0", g_end, nt);
    end
  endtask

  task automatic test_default_slave;
    logic [1:0] g, g_end; logic [2:0] s; int na, nd, nr, nt; bit ok;
    void'(ref_winner(1, 0));
    run_txn(1, 0, 32'h3000_0000, 32'h0, 1, 3, 0, 1, g, s, na, nd, nr, nt, g_end, ok);
    checks++;
    if (g !== 2'b01 || s !== 3'd0 || !ok || g_end !== 2'b00 || na != 2 || nd != 3 || nr != 2) begin
      failures++;
      $display("FAIL default_slave: got grant=%b sel=%0d ok=%0d end=%b a/d/r=%0d/%0d/%0d want 01/0/1/00/2/3/2",
               g, s, ok, g_end, na, nd, nr);
    end
  endtask

  task automatic test_stall;
    logic [1:0] g, g_end; logic [2:0] s; int na, nd, nr, nt; bit ok;
    bit w; logic [31:0] a;
    a = 32'h1000_0200;
    w = ref_winner(1, 0);
    run_txn(1, 0, a, 32'h0, 5, 8, 1, 0, g, s, na, nd, nr, nt, g_end, ok);
    checks++;
    if (na != 6 || !ok || s !== ref_slave(a)) begin
      failures++;
      $display("FAIL stall_addr: got addr_cycles=%0d ok=%0d sel=%0d want 6/1/%0d", na, ok, s, ref_slave(a));
    end
    checks++;
    if (nd != 16 || nr != 1 || nt != 0 || g !== (w ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL stall_data: got data=%0d resp=%0d to=%0d grant=%b want 16/1/0", nd, nr, nt, g);
    end
  endtask

  task automatic test_timeout_data;
    int early, pulses;
    bit w;
    w = ref_winner(0, 1);
    bus.AWVALID_M1 = 1; bus.AWADDR_M1 = 32'h2000_0040;
    tick;
    bus.AWREADY_sel = 1;
    tick;
    bus.AWVALID_M1 = 0; bus.AWREADY_sel = 0;
    early = 0; pulses = 0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick;
      if (bus.wr_timeout || !bus.w_phase) early++;
    end
    bus.WVALID_sel = 1; bus.WREADY_sel = 1; bus.WLAST_sel = 0;
    tick;
    bus.WVALID_sel = 0; bus.WREADY_sel = 0;
    if (bus.wr_timeout || !bus.w_phase) early++;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick;
      pulses += int'(bus.wr_timeout);
      if (k < TIMEOUT && (bus.wr_timeout || !bus.w_phase)) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL to_data_early: got %0d premature cycles want 0", early);
    end
    checks++;
    if (bus.wr_timeout !== 1'b1 || bus.grant !== 2'b00 || bus.slave_sel !== 3'd0 ||
        {bus.aw_phase, bus.w_phase, bus.b_phase} !== 3'b000) begin
      failures++;
      $display("FAIL to_data_fire: got to=%b grant=%b sel=%0d ph=%b%b%b want 1/00/0/000", bus.wr_timeout,
               bus.grant, bus.slave_sel, bus.aw_phase, bus.w_phase, bus.b_phase);
    end
    tick;
    pulses += int'(bus.wr_timeout);
    checks++;
    if (pulses != 1 || w != 1'b1) begin
      failures++;
      $display("FAIL to_data_pulse: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_timeout_resp;
    int early, pulses;
    void'(ref_winner(1, 0));
    bus.AWVALID_M0 = 1; bus.AWADDR_M0 = 32'h0001_0008;
    tick;
    bus.AWREADY_sel = 1;
    tick;
    bus.AWVALID_M0 = 0; bus.AWREADY_sel = 0;
    bus.WVALID_sel = 1; bus.WREADY_sel = 1; bus.WLAST_sel = 1;
    tick;
    bus.WVALID_sel = 0; bus.WREADY_sel = 0; bus.WLAST_sel = 0;
    bus.BREADY_sel = 1;
    early = 0; pulses = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (bus.wr_timeout || !bus.b_phase) early++;
      tick;
      pulses += int'(bus.wr_timeout);
    end
    bus.BREADY_sel = 0;
    checks++;
    if (early != 0 || pulses != 1 || bus.grant !== 2'b00 || bus.b_phase !== 1'b0) begin
      failures++;
      $display("FAIL to_resp: got early=%0d pulses=%0d grant=%b b=%b want 0/1/00/0", early, pulses,
               bus.grant, bus.b_phase);
    end
    tick;
    checks++;
    if (bus.wr_timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_resp_clear: got %b want 0", bus.wr_timeout);
    end
  endtask

  task automatic test_async_reset;
    logic [1:0] g, g_end; logic [2:0] s; int na, nd, nr, nt; bit ok;
    void'(ref_winner(1, 0));
    bus.AWVALID_M0 = 1; bus.AWADDR_M0 = 32'h0000_1000;
    tick;
    bus.AWREADY_sel = 1;
    tick;
    bus.AWVALID_M0 = 0; bus.AWREADY_sel = 0;
    bus.WVALID_sel = 1; bus.WREADY_sel = 1; bus.WLAST_sel = 0;
    tick;
    #2;
    ARESETn = 0;
    #1;
    checks++;
    if ({bus.grant, bus.slave_sel, bus.aw_phase, bus.w_phase, bus.b_phase, bus.wr_timeout} !== 9'd0) begin
      failures++;
      $display("FAIL async_reset: got grant=%b sel=%0d ph=%b%b%b want all zero", bus.grant,
               bus.slave_sel, bus.aw_phase, bus.w_phase, bus.b_phase);
    end
    idle_inputs();
    tick;
    #3;
    ARESETn = 1;
    mdl_last = 1;
    void'(ref_winner(1, 1));
    run_txn(1, 1, 32'h0002_0000, 32'h0000_0004, 0, 1, 0, 0, g, s, na, nd, nr, nt, g_end, ok);
    checks++;
    if (g !== 2'b01 || s !== 3'd3 || !ok) begin
      failures++;
      $display("FAIL post_reset_tie: got grant=%b sel=%0d ok=%0d want 01/3/1", g, s, ok);
    end
  endtask

  task automatic test_random;
    logic [1:0] g, g_end, eg; logic [2:0] s, es; int na, nd, nr, nt; bit ok, r0, r1, w, tg;
    logic [31:0] a0, a1;
    int aw_w, bt, b_w, bad;
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      do begin r0 = 1'($urandom); r1 = 1'($urandom); end while (!r0 && !r1);
      a0 = pick_addr(); a1 = pick_addr();
      aw_w = $urandom_range(0, 3); bt = $urandom_range(1, 4);
      tg = 1'($urandom); b_w = $urandom_range(0, 2);
      w  = ref_winner(r0, r1);
      eg = w ? 2'b10 : 2'b01;
      es = ref_slave(w ? a1 : a0);
      run_txn(r0, r1, a0, a1, aw_w, bt, tg, b_w, g, s, na, nd, nr, nt, g_end, ok);
      checks++;
      if (g !== eg || s !== es || !ok || na != aw_w + 1 || nd != (tg ? 2 * bt : bt) ||
          nr != b_w + 1 || nt != 0 || g_end !== 2'b00) begin
        failures++;
        bad++;
        if (bad < 6)
          $display("FAIL rand_txn%0d: got grant=%b sel=%0d ok=%0d a/d/r=%0d/%0d/%0d to=%0d end=%b want %b/%0d/1/%0d/%0d/%0d/0/00",
                   n, g, s, ok, na, nd, nr, nt, g_end, eg, es, aw_w + 1, tg ? 2 * bt : bt, b_w + 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tie();
    test_single_m1();
    test_default_slave();
    test_stall();
    test_timeout_data();
    test_timeout_resp();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_sched.md
Name: axi_wr_sched

Overview:
- Write-channel scheduler for the AXI interconnect.
- Arbitrates AW requests from two masters (M0, M1) with round-robin priority and decodes the winning AWADDR to one of five slaves or the default slave.
- Holds the route locked across the AW, W and B phases; drives grant, slave-select and phase signals that steer the AW/W/B channel muxes.
- Sits between the masters' AW valid/address lines and the write-path datapath muxes.

Parameters:
- TIMEOUT, 1024: cycles a W or B phase may stall before `wr_timeout` pulses and the route is force-released.
- CNT_W, 11: stall-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- AWVALID_M0  in  1  M0 address request
- AWADDR_M0  in  32  M0 write address
- AWVALID_M1  in  1  M1 address request
- AWADDR_M1  in  32  M1 write address
- AWREADY_sel  in  1  AWREADY of the currently selected slave (muxed by datapath)
- WVALID_sel  in  1  WVALID of the granted master
- WREADY_sel  in  1  WREADY of the selected slave
- WLAST_sel  in  1  WLAST of the granted master
- BVALID_sel  in  1  BVALID of the selected slave
- BREADY_sel  in  1  BREADY of the granted master
- grant  out  2  one-hot master grant; 00 = none
- slave_sel  out  3  0 = default slave, 1..5 = S1..S5
- aw_phase  out  1  AW channel routed
- w_phase  out  1  W channel routed
- b_phase  out  1  B channel routed
- wr_timeout  out  1  one-cycle pulse on stall timeout

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, grant=00, slave_sel=0, all phase outputs 0, wr_timeout=0, last_grant=M1 (so M0 wins the first tie), stall_cnt=0.
- FSM states: IDLE, ADDR, DATA, RESP. All outputs are registered or decoded purely from state (Moore); no combinational path from inputs to outputs.
- IDLE:
  - If any AWVALID_Mx is high, latch the winner into grant and its decoded slave into slave_sel, then go to ADDR on the next edge. Request-to-grant latency is 1 cycle.
  - Arbitration: if only one request, grant it. If both, grant the master not equal to last_grant. Update last_grant on grant.
- ADDR:
  - aw_phase=1.
  - On AWVALID_sel && AWREADY_sel, go to DATA.
  - grant and slave_sel are frozen; a change on the granted master's AWADDR is ignored.
- DATA:
  - w_phase=1.
  - On WVALID_sel && WREADY_sel && WLAST_sel, go to RESP.
  - Beats without WLAST keep the state.
- RESP:
  - b_phase=1.
  - On BVALID_sel && BREADY_sel, go to IDLE; grant and slave_sel clear to 0 in the same transition.
  - Back-to-back: a new grant may be issued in the first IDLE cycle after RESP, giving a 1-cycle bubble.
- Address map (decode of AWADDR[31:0]):
  - S1 0x0000_0000–0x0000_FFFF
  - S2 0x0001_0000–0x0001_FFFF
  - S3 0x0002_0000–0x0002_FFFF
  - S4 0x1000_0000–0x1000_03FF
  - S5 0x2000_0000–0x201F_FFFF
  - all other addresses → slave_sel=0 (default slave, which answers DECERR; the scheduler sequences it identically).
- Stall counter:
  - Cleared on entry to DATA or RESP and on every W-beat handshake; increments each cycle in DATA or RESP otherwise.
  - When it reaches TIMEOUT: pulse wr_timeout for 1 cycle, go to IDLE, clear grant and slave_sel, clear the counter.
  - The counter never counts in IDLE or ADDR; an AW stall is unbounded.
- Simultaneous AW handshake and a new request from the other master: the other master waits; no preemption.
- Reset asserted mid-transaction: immediate return to reset values; no pending state survives.

Decomposition:
- Package `axi_wr_pkg`:
  - state enum {IDLE, ADDR, DATA, RESP}
  - slave-select enum {SEL_DEF=0, SEL_S1..SEL_S5}
  - address-map base/limit localparams for S1..S5
- Sub-module `axi_wr_addr_dec`: combinational, 32-bit address → 3-bit slave_sel; reusable for the read path.

Test Plan:
- M1 alone, AWADDR=0x0002_0010, AWREADY immediate, 4-beat burst, BVALID/BREADY next cycle → grant=10 at cycle+1, slave_sel=3, phases step ADDR→DATA→RESP→IDLE, grant=00 after B handshake.
- M0 and M1 request in the same cycle from reset, twice in a row → first grant=01, second grant=10.
- AWADDR=0x3000_0000 → slave_sel=0, full AW/W/B sequence completes normally.
- AWREADY_sel low for 5 cycles, then WREADY toggling every other cycle across an 8-beat burst → stays in ADDR 5 cycles; enters RESP only on the WLAST handshake; wr_timeout stays 0.
- In DATA, hold WVALID low for TIMEOUT cycles → wr_timeout pulses exactly once, state=IDLE, grant=00 the following cycle.
- Assert ARESETn low mid-DATA (asynchronously, between edges) → outputs go to reset values immediately; the next request after release is granted to M0 on a tie.
